// File: rtl/bus_arbiter_pkg.sv
// System-wide definitions shared by the bus controller and its decoder:
// slave identifiers, the address map and the arbiter state encoding.
package configure;

    localparam int slave_count = 6;

    typedef enum logic [2:0] {ROM, PRINT, CLINT, TIM0, TIM1, RAM} slave_t;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

    typedef enum logic {MASTER_IMEM, MASTER_DMEM} master_t;

    // Each region is [base, top): top is exclusive.
    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] ROM_TOP    = 32'h0001_0000;
    localparam logic [31:0] PRINT_BASE = 32'h0100_0000;
    localparam logic [31:0] PRINT_TOP  = 32'h0100_1000;
    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_TOP  = 32'h0201_0000;
    localparam logic [31:0] TIM0_BASE  = 32'h1000_0000;
    localparam logic [31:0] TIM0_TOP   = 32'h1000_1000;
    localparam logic [31:0] TIM1_BASE  = 32'h1000_1000;
    localparam logic [31:0] TIM1_TOP   = 32'h1000_2000;
    localparam logic [31:0] RAM_BASE   = 32'h8000_0000;
    localparam logic [31:0] RAM_TOP    = 32'h8010_0000;

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] top);
        return (addr >= base) && (addr < top);
    endfunction

endpackage

// File: rtl/bus_decoder.sv
// Combinational address decoder: maps a bus address onto the one-hot slave
// select of the system memory map and flags whether any slave claims it.
module bus_decoder
    import configure::*;
(
    input  logic [31:0]            addr,
    output logic                   hit,
    output logic [slave_count-1:0] sel
);

    always_comb begin
        sel        = '0;
        sel[ROM]   = in_range(addr, ROM_BASE, ROM_TOP);
        sel[PRINT] = in_range(addr, PRINT_BASE, PRINT_TOP);
        sel[CLINT] = in_range(addr, CLINT_BASE, CLINT_TOP);
        sel[TIM0]  = in_range(addr, TIM0_BASE, TIM0_TOP);
        sel[TIM1]  = in_range(addr, TIM1_BASE, TIM1_TOP);
        sel[RAM]   = in_range(addr, RAM_BASE, RAM_TOP);
        hit        = |sel;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin controller joining the core's instruction and data ports onto
// the shared memory bus, with address decode, error completion and watchdog.
module bus_arbiter
    import configure::*;
#(
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   imem_valid,
    input  logic [31:0]            imem_addr,
    output logic [31:0]            imem_rdata,
    output logic                   imem_ready,
    output logic                   imem_error,

    input  logic                   dmem_valid,
    input  logic [31:0]            dmem_addr,
    input  logic [31:0]            dmem_wdata,
    input  logic [3:0]             dmem_wstrb,
    output logic [31:0]            dmem_rdata,
    output logic                   dmem_ready,
    output logic                   dmem_error,

    output logic                   mem_valid,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_wstrb,
    output logic [slave_count-1:0] mem_sel,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_ready
);

    localparam bit          timeout_on   = (timeout_cycles != 0);
    localparam logic [31:0] timeout_last = 32'(timeout_cycles - 1);

    arb_state_t             state, state_n;
    master_t                last, last_n;
    master_t                grant, grant_n;
    logic [31:0]            count, count_n;

    logic                   mem_valid_n;
    logic [31:0]            mem_addr_n;
    logic [31:0]            mem_wdata_n;
    logic [3:0]             mem_wstrb_n;
    logic [slave_count-1:0] mem_sel_n;

    logic                   imem_ready_n, imem_error_n;
    logic [31:0]            imem_rdata_n;
    logic                   dmem_ready_n, dmem_error_n;
    logic [31:0]            dmem_rdata_n;

    logic                   resp_valid, resp_error;
    logic [31:0]            resp_rdata;

    logic                   pick_dmem;
    logic [31:0]            req_addr;
    logic                   dec_hit;
    logic [slave_count-1:0] dec_sel;

    // On a tie the master that was not served last wins.
    assign pick_dmem = dmem_valid && (!imem_valid || (last == MASTER_IMEM));
    assign req_addr  = pick_dmem ? dmem_addr : imem_addr;

    bus_decoder u_decoder (
        .addr (req_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    always_comb begin
        state_n      = state;
        last_n       = last;
        grant_n      = grant;
        count_n      = count;
        mem_valid_n  = mem_valid;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_wstrb_n  = mem_wstrb;
        mem_sel_n    = mem_sel;
        resp_valid   = 1'b0;
        resp_error   = 1'b0;
        resp_rdata   = '0;
        imem_ready_n = 1'b0;
        imem_error_n = 1'b0;
        imem_rdata_n = '0;
        dmem_ready_n = 1'b0;
        dmem_error_n = 1'b0;
        dmem_rdata_n = '0;

        case (state)
            IDLE: begin
                if (imem_valid || dmem_valid) begin
                    grant_n     = pick_dmem ? MASTER_DMEM : MASTER_IMEM;
                    last_n      = grant_n;
                    mem_addr_n  = req_addr;
                    mem_wdata_n = pick_dmem ? dmem_wdata : '0;
                    mem_wstrb_n = pick_dmem ? dmem_wstrb : 4'b0000;
                    if (dec_hit) begin
                        mem_valid_n = 1'b1;
                        mem_sel_n   = dec_sel;
                        count_n     = '0;
                        state_n     = BUSY;
                    end else begin
                        resp_valid = 1'b1;
                        resp_error = 1'b1;
                        state_n    = RESP;
                    end
                end
            end
            BUSY: begin
                // A slave answer in the watchdog's last cycle still counts.
                if (mem_ready) begin
                    mem_valid_n = 1'b0;
                    mem_sel_n   = '0;
                    resp_valid  = 1'b1;
                    resp_rdata  = mem_rdata;
                    state_n     = RESP;
                end else if (timeout_on && (count == timeout_last)) begin
                    mem_valid_n = 1'b0;
                    mem_sel_n   = '0;
                    resp_valid  = 1'b1;
                    resp_error  = 1'b1;
                    state_n     = RESP;
                end else begin
                    count_n = count + 32'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (resp_valid) begin
            if (grant_n == MASTER_DMEM) begin
                dmem_ready_n = 1'b1;
                dmem_error_n = resp_error;
                dmem_rdata_n = resp_rdata;
            end else begin
                imem_ready_n = 1'b1;
                imem_error_n = resp_error;
                imem_rdata_n = resp_rdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last       <= MASTER_DMEM;
            grant      <= MASTER_IMEM;
            count      <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            mem_sel    <= '0;
            imem_ready <= 1'b0;
            imem_error <= 1'b0;
            imem_rdata <= '0;
            dmem_ready <= 1'b0;
            dmem_error <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            state      <= state_n;
            last       <= last_n;
            grant      <= grant_n;
            count      <= count_n;
            mem_valid  <= mem_valid_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_wstrb  <= mem_wstrb_n;
            mem_sel    <= mem_sel_n;
            imem_ready <= imem_ready_n;
            imem_error <= imem_error_n;
            imem_rdata <= imem_rdata_n;
            dmem_ready <= dmem_ready_n;
            dmem_error <= dmem_error_n;
            dmem_rdata <= dmem_rdata_n;
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, single-slave-port bus controller between the core's instruction port (imem) and data port (dmem) and the shared SoC memory bus. It arbitrates round-robin, decodes the address against the system map (rom, print, clint, tim0, tim1, ram), and drives a one-hot slave select. It answers unmapped or timed-out accesses itself with an error completion. Every transaction is registered, so each bus access is atomic and non-overlapping.

## Interface
- timeout_cycles, default 1024: slave response limit in cycles after mem_valid rises; 0 disables the watchdog.
- Address ranges come from the `configure` package; the module has no per-instance map parameters.
- reset  in  1  asynchronous, active-low
- clock  in  1  single clock, all state on rising edge
- imem_valid  in  1  fetch request; held high until imem_ready
- imem_addr  in  32  fetch address
- imem_rdata  out  32  fetch read data, valid with imem_ready
- imem_ready  out  1  one-cycle completion pulse
- imem_error  out  1  unmapped or timeout; valid with imem_ready
- dmem_valid, dmem_addr, dmem_rdata, dmem_ready, dmem_error: same as the imem_* ports, for the data master
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte strobes; 0 means read
- mem_valid  out  1  downstream request
- mem_addr  out  32  registered address
- mem_wdata  out  32  registered write data
- mem_wstrb  out  4  registered strobes; 0 for every imem grant
- mem_sel  out  6  one-hot select, bit order {ram, tim1, tim0, clint, print, rom} (bit 0 = rom)
- mem_rdata  in  32  slave read data
- mem_ready  in  1  slave completion

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE, arbitration.**
  - If any valid is high, pick a master.
  - If only one master requests, it wins.
  - If both request, the master not granted last wins.
  - `last` resets to dmem, so imem wins the first tie.
  - Latch addr, wdata and wstrb, and update `last`.
- **IDLE, decode (mapped address).**
  - A hit is base ≤ addr < top on unsigned 32-bit compares.
  - Assert mem_valid and mem_sel, then go to BUSY.
- **IDLE, decode (unmapped address).**
  - Set error, rdata = 0, and go straight to RESP.
  - Do not assert mem_valid.
- **BUSY.**
  - Hold mem_* stable.
  - On mem_ready: capture mem_rdata, clear error, drop mem_valid and mem_sel, go to RESP.
  - Timeout: if timeout_cycles ≠ 0 and the counter reaches timeout_cycles-1 without mem_ready, drop mem_valid, set error, rdata = 0, go to RESP.
  - If mem_ready arrives in the same cycle as the timeout, mem_ready wins and there is no error.
- **RESP.**
  - Pulse the granted master's ready with its rdata and error.
  - Always go to IDLE next cycle; never accept a request in RESP.
  - This gives the master one cycle to drop or change valid.
- **Counter.** 32 bits, cleared on IDLE→BUSY, incremented in BUSY.
- **Ungranted master.** Its ready and error are 0 and its rdata is 0.

## Timing
- **Reset values:** state IDLE; `last` = dmem; all ready/error/valid/sel outputs 0; mem_addr, mem_wdata, mem_wstrb, all rdata outputs and the counter 0.
- **Reset mid-transaction:** the transaction is abandoned and mem_valid drops immediately (asynchronous reset).
- **Outputs:** all outputs are registered.
- **Mapped access:**
  - Request seen at cycle t; mem_valid high from t+1.
  - Slave mem_ready at cycle k gives master ready at k+1.
  - Minimum latency (zero-wait slave, mem_ready at t+1) is request→ready = 2 cycles.
- **Unmapped access:** ready at t+1.
- **Back-to-back:** next IDLE is at k+2, so the earliest next mem_valid is k+3.
- **Starvation:** with both masters always requesting, grants alternate and neither master starves.

## Structure
- **Shared package additions (`configure`):**
  - enum `slave_t` {ROM, PRINT, CLINT, TIM0, TIM1, RAM};
  - constant `slave_count` = 6;
  - arbiter state enum.
- **Sub-module `bus_decoder`:** combinational addr → {hit, mem_sel[5:0]}. It is reused by testbench checkers.

## Test plan
- Reset, then imem reads 0x00000010, rom answers with 0 wait and rdata 0x00000013 → mem_sel = 000001; imem_ready 2 cycles after request; imem_rdata 0x00000013; imem_error 0.
- imem (0x80000000) and dmem (0x10000004) request in the same cycle → imem granted first; dmem mem_valid rises exactly 2 cycles after imem_ready; then a tie grants imem again, then dmem (alternation).
- dmem writes 0x1000000 with wstrb 4'b0001 and wdata 0x41 → mem_sel = 000010 (print); mem_wstrb 0001; mem_wdata 0x41; ready with error 0.
- dmem reads unmapped 0x30000000 → mem_valid never asserted; dmem_ready one cycle later; dmem_error 1; dmem_rdata 0.
- Slave never responds, timeout_cycles = 4 → mem_valid high 4 cycles then low; dmem_error 1. Repeat with mem_ready on the 4th cycle → no error, rdata captured.
- Assert reset while in BUSY → mem_valid 0 immediately; after release the first imem/dmem tie goes to imem.
